// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: register map and STATUS bit positions shared by the
// UART receive controller and any bus wrapper that decodes its registers.
package uart_rx_ctrl_pkg;

    // Register addresses
    localparam logic [1:0] ADDR_RXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV_LO = 2'd2;
    localparam logic [1:0] ADDR_DIV_HI = 2'd3;

    // STATUS / CTRL bit positions
    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_RX_EN     = 4;

    // Assemble the STATUS byte; bits 7:5 read as zero.
    function automatic logic [7:0] pack_status(input logic not_empty, input logic full,
                                               input logic overrun, input logic frame_err,
                                               input logic rx_en);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_NOT_EMPTY] = not_empty;
        s[STAT_FULL]      = full;
        s[STAT_OVERRUN]   = overrun;
        s[STAT_FRAME_ERR] = frame_err;
        s[STAT_RX_EN]     = rx_en;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_rx_fifo.sv
// rx_fifo: synchronous FIFO for received bytes.
//   push/din  : write din when not full, or when full and a pop happens this cycle
//   pop/dout  : dout is the head entry; pop is ignored while empty
//   full/empty: occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees the slot this cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: register-mapped control for a UART receiver.
//   clk, rst               : clock, async active-high reset
//   rx_done_tick/rx_dout/
//   rx_frame_err           : byte-complete strobe and data from the receiver
//   s_tick                 : oversampling tick to the receiver (period div+1)
//   wr_en/rd_en/addr/wdata : register access; rdata is combinational
//   irq                    : level interrupt (rx_en & (not_empty|overrun|frame_err))
// Registers: 0 RXDATA (read pops), 1 STATUS/CTRL, 2 DIV_LO, 3 DIV_HI.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_dout,
    input  logic       rx_frame_err,
    output logic       s_tick,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);
    logic        rx_en;
    logic [15:0] div;
    logic [15:0] tick_cnt;
    logic        overrun;
    logic        frame_err;

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        push;
    logic        pop;
    logic        rx_event;
    logic        ovr_set;
    logic        fe_set;
    logic        ctrl_wr;

    // ---------------- tick generator ----------------
    // ">=" rather than "==" so a counter stranded above a freshly lowered
    // divisor wraps on the next cycle instead of running through 65535.
    assign s_tick = rx_en & (tick_cnt >= div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          tick_cnt <= '0;
        else if (!rx_en)  tick_cnt <= '0;
        else if (s_tick)  tick_cnt <= '0;
        else              tick_cnt <= tick_cnt + 16'd1;
    end

    // ---------------- receive path ----------------
    assign rx_event = rx_done_tick & rx_en;
    assign push     = rx_event & ~rx_frame_err;
    assign pop      = rd_en & (addr == ADDR_RXDATA);
    // Full with a concurrent pop is not an overrun: the byte takes the freed slot.
    assign ovr_set  = push & fifo_full & ~pop;
    assign fe_set   = rx_event & rx_frame_err;
    assign ctrl_wr  = wr_en & (addr == ADDR_STATUS);

    rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rx_dout),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_en     <= 1'b0;
            div       <= DIV_RESET;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ctrl_wr) rx_en <= wdata[STAT_RX_EN];
            if (wr_en && addr == ADDR_DIV_LO) div[7:0]  <= wdata;
            if (wr_en && addr == ADDR_DIV_HI) div[15:8] <= wdata;
            // Write-one-to-clear; a same-cycle hardware set wins.
            overrun   <= ovr_set | (overrun   & ~(ctrl_wr & wdata[STAT_OVERRUN]));
            frame_err <= fe_set  | (frame_err & ~(ctrl_wr & wdata[STAT_FRAME_ERR]));
        end
    end

    // ---------------- read mux / irq ----------------
    always_comb begin
        rdata = 8'h00;
        case (addr)
            ADDR_RXDATA: rdata = fifo_empty ? 8'h00 : fifo_dout;
            ADDR_STATUS: rdata = pack_status(~fifo_empty, fifo_full, overrun, frame_err, rx_en);
            ADDR_DIV_LO: rdata = div[7:0];
            ADDR_DIV_HI: rdata = div[15:8];
            default:     rdata = 8'h00;
        endcase
    end

    assign irq = rx_en & (~fifo_empty | overrun | frame_err);

endmodule
